// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, PC source selects and the opcode classification rule.
`timescale 1ns/1ps
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JUMP  = 3'd3,
    CLS_JR    = 3'd4
  } instr_class_e;

  localparam logic [1:0] PC_SRC_SEQ   = 2'b00;
  localparam logic [1:0] PC_SRC_JADDR = 2'b01;
  localparam logic [1:0] PC_SRC_RS    = 2'b10;

  // The 11xxxx space is JUMP except for the 1111xx JR corner.
  function automatic instr_class_e classifyOpcode(input logic [5:0] opcode);
    instr_class_e cls;
    case (opcode[5:4])
      2'b00:   cls = CLS_ALU;
      2'b01:   cls = CLS_LOAD;
      2'b10:   cls = CLS_STORE;
      default: cls = (opcode[3:2] == 2'b11) ? CLS_JR : CLS_JUMP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Purely combinational opcode-to-class mapper, shared by the controller and
// any hazard logic that needs to know the class of an in-flight opcode.
`timescale 1ns/1ps
module instr_class_decode
  import kgp_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  output instr_class_e class_o
);

  assign class_o = classifyOpcode(opcode_i);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with handshaked memories
// and a wrapping retired-instruction counter.
`timescale 1ns/1ps
module multicycle_controller
  import kgp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  state,
  output logic        retire,
  output logic [15:0] retired_count
);

  ctrl_state_e  state_q, state_d;
  instr_class_e class_q, class_d;
  instr_class_e decodedClass;
  logic [15:0]  retiredCount_q, retiredCount_d;
  logic         retireRaw;

  instr_class_decode u_classDecode (
    .opcode_i (opcode),
    .class_o  (decodedClass)
  );

  // Opcode is only looked at in DECODE; the class is held until the next one.
  assign class_d        = (state_q == ST_DECODE) ? decodedClass : class_q;
  assign retire         = retireRaw & ~rst;
  assign retiredCount_d = retire ? retiredCount_q + 16'd1 : retiredCount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_FETCH;
      class_q        <= CLS_ALU;
      retiredCount_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      class_q        <= class_d;
      retiredCount_q <= retiredCount_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (class_q)
          CLS_ALU:              state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    retireRaw  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      ST_EXEC: begin
        case (class_q)
          CLS_LOAD, CLS_STORE: alu_src = 1'b1;
          CLS_JUMP: begin
            pc_write  = 1'b1;
            pc_src    = PC_SRC_JADDR;
            retireRaw = 1'b1;
          end
          CLS_JR: begin
            pc_write  = 1'b1;
            pc_src    = PC_SRC_RS;
            retireRaw = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_write = (class_q == CLS_STORE);
        retireRaw = dmem_ready && (class_q == CLS_STORE);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CLS_LOAD);
        retireRaw  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state         = state_q;
  assign retired_count = retiredCount_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction's expected
// per-cycle outputs are queued when it is issued and popped as it executes.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write, mem_to_reg, mem_write, alu_src, retire;
  logic [2:0]  state;
  logic [15:0] retired_count;

  typedef struct {
    logic        imemReady;
    logic        dmemReady;
    logic [5:0]  opcode;
    logic [13:0] expVec;
    logic [15:0] expCount;
  } cycle_t;

  cycle_t      sbQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          retireSeen = 0;
  logic [15:0] modelCount = 16'd0;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .state         (state),
    .retire        (retire),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [13:0] mkVec(input logic [2:0] st, input logic ir, input logic dr,
                                         input logic irw, input logic pcw, input logic [1:0] pcs,
                                         input logic rw, input logic m2r, input logic mw,
                                         input logic as, input logic ret);
    return {st, ir, dr, irw, pcw, pcs, rw, m2r, mw, as, ret};
  endfunction

  function automatic logic [13:0] obsVec();
    return {state, imem_req, dmem_req, ir_write, pc_write, pc_src,
            reg_write, mem_to_reg, mem_write, alu_src, retire};
  endfunction

  // 0 ALU, 1 LOAD, 2 STORE, 3 JUMP, 4 JR
  function automatic int benchClass(input logic [5:0] op);
    if (op[5:4] == 2'b00) return 0;
    if (op[5:4] == 2'b01) return 1;
    if (op[5:4] == 2'b10) return 2;
    if (op[3:2] == 2'b11) return 4;
    return 3;
  endfunction

  task automatic pushCycle(input logic ir, input logic dr, input logic [5:0] op, input logic [13:0] vec);
    cycle_t c;
    c.imemReady = ir;
    c.dmemReady = dr;
    c.opcode    = op;
    c.expVec    = vec;
    c.expCount  = modelCount;
    sbQ.push_back(c);
    if (vec[0]) modelCount = modelCount + 16'd1;
  endtask

  task automatic buildTrace(input logic [5:0] op, input int imemWaits, input int memWaits);
    int cls = benchClass(op);
    for (int i = 0; i < imemWaits; i++)
      pushCycle(1'b0, 1'b1, 6'($urandom()), mkVec(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    pushCycle(1'b1, 1'b1, op, mkVec(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    case (cls)
      0: pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      1, 2: pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0));
      3: pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd2, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 1));
      default: pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd2, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 1));
    endcase
    if (cls == 1 || cls == 2) begin
      for (int i = 0; i < memWaits; i++)
        pushCycle(1'b1, 1'b0, 6'($urandom()), mkVec(3'd3, 0, 1, 0, 0, 2'b00, 0, 0, cls == 2, 0, 0));
      pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd3, 0, 1, 0, 0, 2'b00, 0, 0, cls == 2, 0, cls == 2));
    end
    if (cls == 0 || cls == 1)
      pushCycle(1'b1, 1'b1, 6'($urandom()), mkVec(3'd4, 0, 0, 0, 0, 2'b00, 1, cls == 1, 0, 0, 1));
  endtask

  // Issues one instruction; abortAt >= 0 pulses rst in that cycle instead.
  task automatic applyStimulus(input logic [5:0] op, input int imemWaits, input int memWaits, input int abortAt);
    cycle_t c;
    int n = 0;
    retireSeen = 0;
    buildTrace(op, imemWaits, memWaits);
    while (sbQ.size() > 0) begin
      if (n == abortAt) begin
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("op%0h rstcycle retire", op), 32'(retire), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        sbQ.delete();
        modelCount = 16'd0;
        @(negedge clk);
        checkOutput($sformatf("op%0h postrst vec", op), 32'(obsVec()),
                    32'(mkVec(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)));
        checkOutput($sformatf("op%0h postrst count", op), 32'(retired_count), 32'd0);
        @(posedge clk); #1;
      end else begin
        c = sbQ.pop_front();
        imem_ready = c.imemReady;
        dmem_ready = c.dmemReady;
        opcode     = c.opcode;
        @(negedge clk);
        checkOutput($sformatf("op%0h cyc%0d vec", op, n), 32'(obsVec()), 32'(c.expVec));
        checkOutput($sformatf("op%0h cyc%0d count", op, n), 32'(retired_count), 32'(c.expCount));
        retireSeen += int'(retire);
        @(posedge clk); #1;
      end
      n++;
    end
  endtask

  task automatic idleCheck(input string tag);
    imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 6'($urandom());
    @(negedge clk);
    checkOutput({tag, " idle vec"}, 32'(obsVec()), 32'(mkVec(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)));
    checkOutput({tag, " idle count"}, 32'(retired_count), 32'(modelCount));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset vec", 32'(obsVec()), 32'(mkVec(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)));
    checkOutput("reset count", 32'(retired_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(6'b000001, 0, 0, -1);
    idleCheck("alu");
    applyStimulus(6'b010000, 0, 3, -1);
    applyStimulus(6'b100000, 0, 2, -1);
    applyStimulus(6'b100000, 0, 0, -1);
    applyStimulus(6'b111100, 0, 0, -1);
    applyStimulus(6'b110000, 1, 0, -1);
    applyStimulus(6'b111000, 0, 0, -1);
    applyStimulus(6'b011111, 2, 1, -1);
    applyStimulus(6'b001111, 0, 0, -1);
    applyStimulus(6'b101111, 0, 0, -1);
    idleCheck("mix");

    applyStimulus(6'b010000, 0, 5, 5);
    applyStimulus(6'b000001, 0, 0, -1);
    idleCheck("afterRst");

    imem_ready = 1'b0; dmem_ready = 1'b0;
    force dut.retiredCount_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.retiredCount_q;
    modelCount = 16'hFFFF;
    idleCheck("preload");
    applyStimulus(6'b110000, 0, 0, -1);
    checkOutput("wrap retires", 32'(retireSeen), 32'd1);
    idleCheck("wrap");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
